// File: rtl/inst_mem_responder_pkg.sv
// Shared types, reset constants and FSM encoding for the instruction-fetch burst responder.
package inst_mem_responder_pkg;

   typedef logic [31:0] ADDR_TYPE;
   typedef logic [31:0] INST_TYPE;

   localparam logic     TRUE       = 1'b1;
   localparam logic     FALSE      = 1'b0;
   localparam INST_TYPE INST_RESET = 32'h0000_0000;
   localparam ADDR_TYPE ADDR_RESET = 32'h0000_0000;

   localparam int unsigned BURST_LEN_DEFAULT = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDone
   } state_e;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetcher-facing handshake and byte-wide RAM arbiter port of the burst responder.
interface inst_mem_responder_if;
   import inst_mem_responder_pkg::*;

   logic      enable_from_fetcher;
   ADDR_TYPE  address_from_fetcher;
   logic      reset_from_fetcher;
   INST_TYPE  inst_to_fetcher;
   logic      one_inst_finish_to_fetcher;
   logic      end_to_fetcher;
   logic      mem_req;
   logic      mem_gnt;
   ADDR_TYPE  mem_a;
   logic [7:0] mem_din;

   modport slave (
      input  enable_from_fetcher, address_from_fetcher, reset_from_fetcher, mem_gnt, mem_din,
      output inst_to_fetcher, one_inst_finish_to_fetcher, end_to_fetcher, mem_req, mem_a
   );

   modport master (
      output enable_from_fetcher, address_from_fetcher, reset_from_fetcher, mem_gnt, mem_din,
      input  inst_to_fetcher, one_inst_finish_to_fetcher, end_to_fetcher, mem_req, mem_a
   );

endinterface

// File: rtl/inst_mem_responder_byte_assembler.sv
// Captures returning RAM bytes into little-endian lanes and emits one pulse per 32-bit word.
module inst_byte_assembler
   import inst_mem_responder_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   input  logic       abort_i,
   input  logic       issue_i,
   input  logic [7:0] mem_din_i,
   output logic       inst_done_o,
   output INST_TYPE   inst_word_o
);

   logic [2:0][7:0] lane_q, lane_d;
   logic [1:0]      capture_cnt_q, capture_cnt_d;
   logic            inflight_q, inflight_d;
   logic            pending_q, pending_d;
   logic            done_q, done_d;
   INST_TYPE        word_q, word_d;

   always_comb begin
      lane_d        = lane_q;
      capture_cnt_d = capture_cnt_q;
      inflight_d    = issue_i;
      pending_d     = pending_q;
      done_d        = FALSE;
      word_d        = word_q;
      if (abort_i) begin
         // Byte still on its way back is dropped; the word register keeps its last value.
         inflight_d    = FALSE;
         pending_d     = FALSE;
         capture_cnt_d = 2'd0;
      end else begin
         if (pending_q && rdy_in) begin
            done_d    = TRUE;
            pending_d = FALSE;
         end
         if (inflight_q) begin
            capture_cnt_d = capture_cnt_q + 2'd1;
            if (capture_cnt_q == 2'd3) begin
               word_d = {mem_din_i, lane_q};
               if (rdy_in) begin
                  done_d = TRUE;
               end else begin
                  pending_d = TRUE;
               end
            end else begin
               lane_d[capture_cnt_q] = mem_din_i;
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         lane_q        <= '0;
         capture_cnt_q <= 2'd0;
         inflight_q    <= FALSE;
         pending_q     <= FALSE;
         done_q        <= FALSE;
         word_q        <= INST_RESET;
      end else begin
         lane_q        <= lane_d;
         capture_cnt_q <= capture_cnt_d;
         inflight_q    <= inflight_d;
         pending_q     <= pending_d;
         done_q        <= done_d;
         word_q        <= word_d;
      end
   end

   assign inst_done_o = done_q;
   assign inst_word_o = word_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction fetch burst responder: issues 4*BURST_LEN byte reads and returns assembled words.
// Define INST_MEM_ALIGN_EN to force the accepted start address onto a word boundary.
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   inst_mem_responder_if.slave  bus
);

   localparam int unsigned NumBytes = 4 * BURST_LEN;
   localparam int unsigned IssW     = $clog2(NumBytes + 1);
   localparam int unsigned FinW     = $clog2(BURST_LEN + 1);

   state_e          state_q, state_d;
   ADDR_TYPE        start_q, start_d;
   logic [IssW-1:0] issue_cnt_q, issue_cnt_d;
   logic [FinW-1:0] fin_cnt_q, fin_cnt_d;
   logic            req_q, req_d;
   logic            end_q, end_d;
   logic            abort;
   logic            issue;
   logic            inst_done;
   INST_TYPE        inst_word;

   assign abort       = bus.reset_from_fetcher && (state_q != StIdle);
   assign issue       = (state_q == StRead) && bus.mem_req && bus.mem_gnt && !abort;
   assign bus.mem_req = req_q & rdy_in;
   assign bus.mem_a   = start_q + ADDR_TYPE'(issue_cnt_q);

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      issue_cnt_d = issue_cnt_q;
      fin_cnt_d   = fin_cnt_q;
      req_d       = req_q;
      end_d       = FALSE;
      unique case (state_q)
         StIdle: begin
            if (bus.enable_from_fetcher && !bus.reset_from_fetcher && rdy_in) begin
               state_d     = StRead;
`ifdef INST_MEM_ALIGN_EN
               start_d     = bus.address_from_fetcher & 32'hFFFF_FFFC;
`else
               start_d     = bus.address_from_fetcher;
`endif
               issue_cnt_d = '0;
               fin_cnt_d   = '0;
               req_d       = TRUE;
            end
         end
         StRead: begin
            if (abort) begin
               state_d = StIdle;
               req_d   = FALSE;
            end else begin
               if (issue) begin
                  issue_cnt_d = issue_cnt_q + IssW'(1);
                  if (issue_cnt_q == IssW'(NumBytes - 1)) begin
                     req_d = FALSE;
                  end
               end
               if (inst_done) begin
                  fin_cnt_d = fin_cnt_q + FinW'(1);
               end
               // The count survives rdy_in=0, so a stalled last finish still closes the burst.
               if (rdy_in && (fin_cnt_d == FinW'(BURST_LEN))) begin
                  state_d = StDone;
                  end_d   = TRUE;
               end
            end
         end
         StDone: begin
            if (abort || rdy_in) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         start_q     <= ADDR_RESET;
         issue_cnt_q <= '0;
         fin_cnt_q   <= '0;
         req_q       <= FALSE;
         end_q       <= FALSE;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         issue_cnt_q <= issue_cnt_d;
         fin_cnt_q   <= fin_cnt_d;
         req_q       <= req_d;
         end_q       <= end_d;
      end
   end

   inst_byte_assembler u_assembler (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .abort_i     (abort),
      .issue_i     (issue),
      .mem_din_i   (bus.mem_din),
      .inst_done_o (inst_done),
      .inst_word_o (inst_word)
   );

   assign bus.inst_to_fetcher            = inst_word;
   assign bus.one_inst_finish_to_fetcher = inst_done;
   assign bus.end_to_fetcher             = end_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: table of bursts plus abort and async-reset sequences.
module tb_inst_mem_responder;

   localparam int BL = 8;

`ifdef INST_MEM_ALIGN_EN
   localparam logic [31:0] V3_A    = 32'h0000_1000;
   localparam logic [31:0] V3_INST = 32'h0000_0513;
`else
   localparam logic [31:0] V3_A    = 32'h0000_1002;
   localparam logic [31:0] V3_INST = 32'h0513_0000;
`endif

   typedef struct {
      logic [31:0] addr;
      int          mode;
      int          stall_at;
      int          stall_len;
      int          rdy_low_at;
      logic [31:0] first_a;
      logic [31:0] first_inst;
      int          shift_from;
      int          shift;
      int          end_t;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   ram_mode = 0;
   int   checks   = 0;
   int   errors   = 0;

   inst_mem_responder_if bus ();

   inst_mem_responder dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input int mode, input logic [31:0] a);
      logic [7:0] pat [4];
      pat[0] = 8'h13; pat[1] = 8'h05; pat[2] = 8'h00; pat[3] = 8'h00;
      if (mode == 0) return pat[a[1:0]];
      return a[7:0] + 8'h40;
   endfunction

   function automatic logic [31:0] exp_inst(input int mode, input logic [31:0] base, input int i);
      logic [31:0] a;
      a = base + 32'(4 * i);
      return {ram_byte(mode, a + 32'd3), ram_byte(mode, a + 32'd2),
              ram_byte(mode, a + 32'd1), ram_byte(mode, a)};
   endfunction

   // RAM answers one cycle after each granted issue.
   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_gnt) bus.mem_din <= ram_byte(ram_mode, bus.mem_a);
      else bus.mem_din <= 8'hEE;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_burst(input int vi, input vec_t v);
      logic [31:0] fin_val[$];
      int          fin_t[$];
      logic [31:0] iss[$];
      int          end_t;
      int          overlap;
      int          bad;
      int          et;
      end_t   = -1;
      overlap = 0;
      bad     = 0;
      ram_mode = v.mode;
      bus.address_from_fetcher = v.addr;
      bus.reset_from_fetcher   = 1'b0;
      bus.enable_from_fetcher  = 1'b1;
      bus.mem_gnt = 1'b1;
      rdy = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 200; n++) begin
         bus.mem_gnt = !(v.stall_len > 0 && n >= v.stall_at && n < v.stall_at + v.stall_len);
         rdy = (n != v.rdy_low_at);
         #1;
         if (bus.one_inst_finish_to_fetcher) begin
            fin_val.push_back(bus.inst_to_fetcher);
            fin_t.push_back(n);
         end
         if (bus.one_inst_finish_to_fetcher && bus.end_to_fetcher) overlap++;
         if (bus.mem_req && bus.mem_gnt) iss.push_back(bus.mem_a);
         if (bus.end_to_fetcher) begin
            end_t = n;
            break;
         end
         @(negedge clk);
      end
      bus.enable_from_fetcher = 1'b0;
      bus.mem_gnt = 1'b1;
      rdy = 1'b1;
      check($sformatf("v%0d end_time", vi), end_t, v.end_t);
      check($sformatf("v%0d fin_count", vi), fin_val.size(), BL);
      check($sformatf("v%0d end_fin_overlap", vi), overlap, 0);
      check($sformatf("v%0d issue_count", vi), iss.size(), 4 * BL);
      check($sformatf("v%0d first_mem_a", vi), (iss.size() > 0) ? iss[0] : 32'hDEAD_BEEF,
            v.first_a);
      for (int j = 0; j < iss.size(); j++) if (iss[j] !== v.first_a + 32'(j)) bad++;
      check($sformatf("v%0d addr_seq_bad", vi), bad, 0);
      check($sformatf("v%0d first_inst", vi),
            (fin_val.size() > 0) ? fin_val[0] : 32'hDEAD_BEEF, v.first_inst);
      for (int i = 0; i < fin_val.size() && i < BL; i++) begin
         et = 4 * i + 5 + ((i >= v.shift_from) ? v.shift : 0);
         check($sformatf("v%0d inst%0d", vi, i), fin_val[i], exp_inst(v.mode, v.first_a, i));
         check($sformatf("v%0d fin%0d_time", vi, i), fin_t[i], et);
      end
      @(negedge clk);
   endtask

   task automatic partial_burst(input logic [31:0] addr, input int mode, input int upto,
                                output int nfin);
      nfin = 0;
      ram_mode = mode;
      bus.address_from_fetcher = addr;
      bus.reset_from_fetcher   = 1'b0;
      bus.enable_from_fetcher  = 1'b1;
      bus.mem_gnt = 1'b1;
      rdy = 1'b1;
      for (int n = 0; n <= upto; n++) begin
         @(negedge clk);
         if (bus.one_inst_finish_to_fetcher) nfin++;
      end
   endtask

   initial begin
      vec_t vecs[5];
      vec_t v2000;
      int   nfin;
      vecs[0] = '{32'h1000, 0, -1, 0, -1, 32'h1000, 32'h0000_0513, 0, 0, 34};
      vecs[1] = '{32'h1000, 0, 9, 3, -1, 32'h1000, 32'h0000_0513, 2, 3, 37};
      vecs[2] = '{32'h1000, 1, -1, 0, 4, 32'h1000, 32'h4342_4140, 0, 1, 35};
      vecs[3] = '{32'h1002, 0, -1, 0, -1, V3_A, V3_INST, 0, 0, 34};
      vecs[4] = '{32'hFFFF_FFF8, 1, -1, 0, -1, 32'hFFFF_FFF8, 32'h3B3A_3938, 0, 0, 34};
      v2000   = '{32'h2000, 1, -1, 0, -1, 32'h2000, 32'h4342_4140, 0, 0, 34};

      rst = 1'b1;
      rdy = 1'b1;
      bus.enable_from_fetcher  = 1'b0;
      bus.reset_from_fetcher   = 1'b0;
      bus.address_from_fetcher = 32'h0;
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst inst", bus.inst_to_fetcher, 32'h0);
      check("rst finish", 32'(bus.one_inst_finish_to_fetcher), 32'h0);
      check("rst end", 32'(bus.end_to_fetcher), 32'h0);
      check("rst mem_req", 32'(bus.mem_req), 32'h0);
      check("rst mem_a", bus.mem_a, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle mem_req", 32'(bus.mem_req), 32'h0);

      for (int vi = 0; vi < 5; vi++) run_burst(vi, vecs[vi]);

      // Abort one cycle after the third finish, then restart at 0x2000 two cycles later.
      partial_burst(32'h1000, 0, 14, nfin);
      check("abort fin_before", nfin, 3);
      bus.reset_from_fetcher = 1'b1;
      @(negedge clk);
      check("abort mem_req", 32'(bus.mem_req), 32'h0);
      check("abort finish", 32'(bus.one_inst_finish_to_fetcher), 32'h0);
      check("abort end", 32'(bus.end_to_fetcher), 32'h0);
      bus.reset_from_fetcher  = 1'b0;
      bus.enable_from_fetcher = 1'b0;
      @(negedge clk);
      check("abort quiet", 32'({bus.one_inst_finish_to_fetcher, bus.end_to_fetcher,
                                bus.mem_req}), 32'h0);
      check("abort inst_hold", bus.inst_to_fetcher, 32'h0000_0513);
      run_burst(5, v2000);

      // Asynchronous reset between edges mid-burst.
      partial_burst(32'h1000, 0, 10, nfin);
      check("arst fin_before", nfin, 2);
      check("arst inst_before", bus.inst_to_fetcher, 32'h0000_0513);
      #2 rst = 1'b1;
      #1;
      check("arst inst", bus.inst_to_fetcher, 32'h0);
      check("arst mem_req", 32'(bus.mem_req), 32'h0);
      check("arst mem_a", bus.mem_a, 32'h0);
      check("arst pulses", 32'({bus.one_inst_finish_to_fetcher, bus.end_to_fetcher}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.enable_from_fetcher = 1'b0;
      @(negedge clk);
      run_burst(6, vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
